ntt_layer_ctrl: RTL and testbench

Sequencer for the NTT/INTT butterfly datapath in the ML-DSA-65 accelerator. On a start pulse it walks all butterfly layers of a 256-coefficient polynomial. It issues coefficient-RAM read beats, twiddle indices, the mode/permute controls for the lane permutation network, and write-back beats delayed to match the butterfly pipeline. It serialises layers so that layer k+1 never reads a row before layer k has written it.

---
 rtl/ntt_layer_ctrl_if.sv | 32 +++
 rtl/ntt_layer_ctrl.sv | 139 +++++++++++++
 tb/tb_ntt_layer_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ntt_layer_ctrl_if.sv
// Control/status bundle between the NTT layer sequencer and its user.
// Sequencer is the slave (samples i_*, drives o_*); the driver side is the master.
interface ntt_layer_ctrl_if #(
  parameter int AW = 2,
  parameter int LW = 3
);
  logic              i_start;
  logic              i_intt;
  logic              i_abort;
  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [AW-1:0]     o_rd_addr;
  logic [LW-1:0]     o_layer;
  logic [LW+AW-1:0]  o_tw_idx;
  logic              o_wr_en;
  logic [AW-1:0]     o_wr_addr;
  logic              o_intt;
  logic              o_permute;

  modport master (
    output i_start, i_intt, i_abort,
    input  o_busy, o_done, o_rd_en, o_rd_addr, o_layer, o_tw_idx,
           o_wr_en, o_wr_addr, o_intt, o_permute
  );

  modport slave (
    input  i_start, i_intt, i_abort,
    output o_busy, o_done, o_rd_en, o_rd_addr, o_layer, o_tw_idx,
           o_wr_en, o_wr_addr, o_intt, o_permute
  );
endinterface

// File: rtl/ntt_layer_ctrl.sv
// NTT/INTT layer sequencer: per layer, ROWS read beats then a drain until the last write-back.
// Writes trail reads by exactly BFU_LATENCY cycles; no backpressure, abort/reset flush pending writes.
module ntt_layer_ctrl #(
  parameter int HALF_NUM_BFU = 16,
  parameter int NUM_COEF     = 256,
  parameter int LOG_N        = 8,
  parameter int BFU_LATENCY  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  ntt_layer_ctrl_if.slave     bus
);
  localparam int ROWS = NUM_COEF / (4 * HALF_NUM_BFU);
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW   = $clog2(LOG_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] beat_q, beat_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          intt_q, intt_d;

  logic [BFU_LATENCY-1:0] dl_vld_q;
  logic [BFU_LATENCY-1:0] dl_last_q;
  logic [AW-1:0]          dl_row_q [BFU_LATENCY];

  logic rd_en;
  logic last_layer;
  logic drain_end;

  assign rd_en      = (state_q == S_READ);
  assign last_layer = intt_q ? (layer_q == '0) : (layer_q == LW'(LOG_N - 1));
  // Reads of one layer are issued in row order, so the tail of the delay line
  // showing the final row means the whole layer has been written back.
  assign drain_end  = dl_vld_q[BFU_LATENCY-1] && (dl_row_q[BFU_LATENCY-1] == AW'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    layer_d = layer_q;
    intt_d  = intt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          intt_d  = bus.i_intt;
          layer_d = bus.i_intt ? LW'(LOG_N - 1) : '0;
          beat_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (beat_q == AW'(ROWS - 1)) begin
          state_d = S_DRAIN;
        end else begin
          beat_d = beat_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          if (last_layer) begin
            state_d = S_DONE;
          end else begin
            layer_d = intt_q ? (layer_q - LW'(1)) : (layer_q + LW'(1));
            beat_d  = '0;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (bus.i_abort) begin
      state_d = S_IDLE;
      beat_d  = beat_q;
      layer_d = layer_q;
      intt_d  = intt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      layer_q <= '0;
      intt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      layer_q <= layer_d;
      intt_q  <= intt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dl_vld_q  <= '0;
      dl_last_q <= '0;
      for (int i = 0; i < BFU_LATENCY; i++) begin
        dl_row_q[i] <= '0;
      end
    end else if (bus.i_abort) begin
      dl_vld_q  <= '0;
      dl_last_q <= '0;
      for (int i = 0; i < BFU_LATENCY; i++) begin
        dl_row_q[i] <= '0;
      end
    end else begin
      dl_vld_q[0]  <= rd_en;
      dl_last_q[0] <= last_layer;
      dl_row_q[0]  <= beat_q;
      for (int i = 1; i < BFU_LATENCY; i++) begin
        dl_vld_q[i]  <= dl_vld_q[i-1];
        dl_last_q[i] <= dl_last_q[i-1];
        dl_row_q[i]  <= dl_row_q[i-1];
      end
    end
  end

  assign bus.o_busy    = (state_q == S_READ) || (state_q == S_DRAIN);
  assign bus.o_done    = (state_q == S_DONE);
  assign bus.o_rd_en   = rd_en;
  assign bus.o_rd_addr = rd_en ? beat_q : '0;
  assign bus.o_layer   = layer_q;
  assign bus.o_tw_idx  = {layer_q, bus.o_rd_addr};
  assign bus.o_wr_en   = dl_vld_q[BFU_LATENCY-1];
  assign bus.o_wr_addr = dl_row_q[BFU_LATENCY-1];
  assign bus.o_intt    = intt_q;
  assign bus.o_permute = dl_vld_q[BFU_LATENCY-1] & intt_q & dl_last_q[BFU_LATENCY-1];
endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// Bench for ntt_layer_ctrl: expected per-cycle outputs come from a schedule
// built out of the layer/row/latency timing rules, compared every cycle.
module tb_ntt_layer_ctrl;
  localparam int HALF  = 16;
  localparam int NC    = 256;
  localparam int LOGN  = 8;
  localparam int LAT   = 4;
  localparam int ROWS  = NC / (4 * HALF);
  localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW    = $clog2(LOGN);
  localparam int LCYC  = ROWS + LAT;
  localparam int MAXC  = 2048;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [LW-1:0] layer;
    logic [LW+AW-1:0] tw;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          permute;
    logic          intt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_layer_ctrl_if #(.AW(AW), .LW(LW)) bus ();

  ntt_layer_ctrl #(
    .HALF_NUM_BFU(HALF),
    .NUM_COEF(NC),
    .LOG_N(LOGN),
    .BFU_LATENCY(LAT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  exp_t ex [MAXC];
  int   cyc = 0;
  int   idle_from = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input int c, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, expv);
    end
  endtask

  task automatic check_cycle(input int c);
    chk("busy",    c, 16'(bus.o_busy),    16'(ex[c].busy));
    chk("done",    c, 16'(bus.o_done),    16'(ex[c].done));
    chk("rd_en",   c, 16'(bus.o_rd_en),   16'(ex[c].rd_en));
    chk("wr_en",   c, 16'(bus.o_wr_en),   16'(ex[c].wr_en));
    chk("permute", c, 16'(bus.o_permute), 16'(ex[c].permute));
    chk("intt",    c, 16'(bus.o_intt),    16'(ex[c].intt));
    if (ex[c].rd_en) begin
      chk("rd_addr", c, 16'(bus.o_rd_addr), 16'(ex[c].rd_addr));
      chk("layer",   c, 16'(bus.o_layer),   16'(ex[c].layer));
      chk("tw_idx",  c, 16'(bus.o_tw_idx),  16'(ex[c].tw));
    end
    if (ex[c].wr_en) begin
      chk("wr_addr", c, 16'(bus.o_wr_addr), 16'(ex[c].wr_addr));
    end
  endtask

  // Schedule of a full run accepted at cycle s: layer n reads rows 0..ROWS-1
  // from s+1+n*LCYC, each row written back LAT cycles later.
  task automatic plan_run(input int s, input logic m);
    int lay, rc, wc;
    for (int k = s + 1; k < MAXC; k++) begin
      ex[k] = '0;
      ex[k].intt = m;
    end
    for (int n = 0; n < LOGN; n++) begin
      lay = m ? (LOGN - 1 - n) : n;
      for (int r = 0; r < ROWS; r++) begin
        rc = s + 1 + n * LCYC + r;
        wc = rc + LAT;
        ex[rc].rd_en   = 1'b1;
        ex[rc].rd_addr = AW'(r);
        ex[rc].layer   = LW'(lay);
        ex[rc].tw      = (LW + AW)'(lay * ROWS + r);
        ex[wc].wr_en   = 1'b1;
        ex[wc].wr_addr = AW'(r);
        ex[wc].permute = m && (lay == 0);
      end
    end
    for (int k = s + 1; k <= s + LOGN * LCYC; k++) ex[k].busy = 1'b1;
    ex[s + LOGN * LCYC + 1].done = 1'b1;
    idle_from = s + LOGN * LCYC + 2;
  endtask

  task automatic model_abort(input int c);
    logic keep;
    keep = ex[c].intt;
    for (int k = c + 1; k < MAXC; k++) begin
      ex[k] = '0;
      ex[k].intt = keep;
    end
    idle_from = c + 1;
  endtask

  task automatic model_reset(input int c);
    for (int k = c; k < MAXC; k++) ex[k] = '0;
    idle_from = c;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle(cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC - LOGN * LCYC - 4) begin
      $display("FAIL cycle_budget observed=%0d limit=%0d", cyc, MAXC - LOGN * LCYC - 4);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic step(input logic st, input logic md, input logic ab);
    bus.i_start = st;
    bus.i_intt  = md;
    bus.i_abort = ab;
    if (ab) model_abort(cyc);
    else if (st && cyc >= idle_from) plan_run(cyc, md);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0);
  endtask

  initial begin
    logic md;
    int   k;
    for (int i = 0; i < MAXC; i++) ex[i] = '0;
    bus.i_start = 1'b0;
    bus.i_intt  = 1'b0;
    bus.i_abort = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    idle(2);

    // Forward NTT, then inverse NTT.
    step(1'b1, 1'b0, 1'b0);
    idle(LOGN * LCYC + 6);
    step(1'b1, 1'b1, 1'b0);
    idle(LOGN * LCYC + 6);

    // Start held high: back-to-back runs, restart only once IDLE is reached.
    md = 1'($urandom);
    for (int i = 0; i < 2 * LOGN * LCYC + 12; i++) step(1'b1, md, 1'b0);
    idle(LOGN * LCYC + 6);

    // Abort while layer 1 is reading, then a clean full run.
    step(1'b1, 1'($urandom), 1'b0);
    idle(9);
    step(1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'($urandom), 1'b0);
    idle(LOGN * LCYC + 6);

    // Abort at a random point of a run.
    step(1'b1, 1'($urandom), 1'b0);
    k = $urandom_range(1, LOGN * LCYC + 4);
    idle(k);
    step(1'b0, 1'b0, 1'b1);
    idle(LAT + 2);

    // Asynchronous reset in cycle 30 of a run.
    step(1'b1, 1'($urandom), 1'b0);
    idle(29);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    rst_n = 1'b0;
    model_reset(cyc);
    repeat (3) tick();
    rst_n = 1'b1;
    idle(5);

    // Start and abort together in IDLE must not start.
    step(1'b1, 1'b1, 1'b1);
    idle(5);

    // Random-mode runs with random gaps.
    for (int r = 0; r < 2; r++) begin
      idle($urandom_range(0, 5));
      step(1'b1, 1'($urandom), 1'b0);
      idle(LOGN * LCYC + 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
